// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor stage, LSB first, WIDTH cycles per operation.
// Optional `SERIAL_SUB_OVF_EN adds a two's-complement overflow output (ovf).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             w_last;
  logic             w_d;
  logic             w_br_nxt;

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands shift right; each difference bit enters the result at the MSB,
  // so after WIDTH steps r_res holds the full difference in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= in0;
            r_b   <= in1;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_bout <= w_br_nxt;
        end
        default: ;
      endcase
    end
  end

  assign out  = r_res;
  assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the last step r_a[0]/r_b[0] are the operand MSBs and w_d is the result MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == BUSY && w_last) begin
      r_ovf <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4); define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out;
  logic       bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk({tag, ".rdy_timeout"}, 32'(in_ready), 1);
  endtask

  // Accept one operand pair with out_ready high and check latency and result.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] e_out, input logic e_b, input logic e_ovf);
    int n;
    wait_ready(tag);
    in0 = a;
    in1 = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".lat"},  32'(n), 5);
    chk({tag, ".out"},  32'(out), 32'(e_out));
    chk({tag, ".bout"}, 32'(bout), 32'(e_b));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, ".ovf"},  32'(ovf), 32'(e_ovf));
`else
    if (e_ovf === 1'bx) $display("unexpected x in ovf expectation");
`endif
    step();
    chk({tag, ".rdy_after"}, 32'(in_ready), 1);
  endtask

  initial begin
    int acc[$];
    int n;
    rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in0 = '0;
    in1 = '0;
    step();
    step();
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready",  32'(in_ready), 0);
    chk("rst.out",       32'(out), 0);
    chk("rst.bout",      32'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst.ovf",       32'(ovf), 0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rst.rdy_rel", 32'(in_ready), 1);

    run_op("7-3",   4'd7,  4'd3,  4'd4,  1'b0, 1'b0);
    run_op("3-7",   4'd3,  4'd7,  4'd12, 1'b1, 1'b0);
    run_op("0-0",   4'd0,  4'd0,  4'd0,  1'b0, 1'b0);
    run_op("15-15", 4'd15, 4'd15, 4'd0,  1'b0, 1'b0);
    run_op("0-15",  4'd0,  4'd15, 4'd1,  1'b1, 1'b0);
    run_op("15-0",  4'd15, 4'd0,  4'd15, 1'b0, 1'b0);

    // Result held in DONE while out_ready is low; new operands must be ignored.
    wait_ready("hold");
    in0 = 4'd9;
    in1 = 4'd2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("hold.lat", 32'(n), 5);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in0 = 4'd5;
      in1 = 4'd5;
      chk("hold.out",       32'(out), 7);
      chk("hold.out_valid", 32'(out_valid), 1);
      chk("hold.in_ready",  32'(in_ready), 0);
      step();
    end
    chk("hold.out_end", 32'(out), 7);
    chk("hold.bout",    32'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("hold.ovf",     32'(ovf), 1);
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold.idle_vld", 32'(out_valid), 0);
    chk("hold.idle_rdy", 32'(in_ready), 1);
    chk("hold.out_kept", 32'(out), 7);

    // Reset during the second BUSY cycle abandons the operation.
    in0 = 4'd12;
    in1 = 4'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst.out_valid", 32'(out_valid), 0);
    chk("mid_rst.out",       32'(out), 0);
    chk("mid_rst.in_ready",  32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst.idle_rdy",  32'(in_ready), 1);
    step();
    chk("mid_rst.no_result", 32'(out_valid), 0);
    run_op("9-1", 4'd9, 4'd1, 4'd8, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("8-1",  4'd8, 4'd1,  4'd7, 1'b0, 1'b1);
    run_op("7-15", 4'd7, 4'd15, 4'd8, 1'b1, 1'b1);
    run_op("5-3",  4'd5, 4'd3,  4'd2, 1'b0, 1'b0);
`endif

    // Back-to-back: acceptances must be exactly 6 cycles apart.
    wait_ready("b2b");
    in0 = 4'd6;
    in1 = 4'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (in_ready) acc.push_back(c);
      if (out_valid) chk("b2b.out", 32'(out), 5);
    end
    in_valid = 1'b0;
    chk("b2b.count_ok", (acc.size() >= 3) ? 32'd1 : 32'd0, 1);
    if (acc.size() >= 3) begin
      chk("b2b.gap1", 32'(acc[1] - acc[0]), 6);
      chk("b2b.gap2", 32'(acc[2] - acc[1]), 6);
    end
    wait_ready("drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
